param_ram: RTL and testbench
============================

PARAM_RAM -- requirements
Module: param_ram

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the word width in bits; it SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning the request address width.
REQ-003 The block SHALL have parameter DEPTH_LOG2, default 12, meaning the storage depth is 2^DEPTH_LOG2 words (4096 at default).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 The block SHALL have port req_valid, input, 1 bit: the request is present.
REQ-007 The block SHALL have port req_ready, output, 1 bit: the block accepts the request this cycle.
REQ-008 The block SHALL have port req_write, input, 1 bit: 1 = write, 0 = read.
REQ-009 The block SHALL have port req_addr, input, ADDR_W bits: the word address.
REQ-010 The block SHALL have port req_wdata, input, DATA_W bits: the write data.
REQ-011 The block SHALL have port req_be, input, DATA_W/8 bits: the per-byte write enable; bit i covers bits [8i+7:8i].
REQ-012 The block SHALL have port rsp_valid, output, 1 bit: the read data is valid.
REQ-013 The block SHALL have port rsp_ready, input, 1 bit: the consumer takes the read data.
REQ-014 The block SHALL have port rsp_rdata, output, DATA_W bits: the read data.
REQ-015 The block SHALL have port busy, output, 1 bit: the initialisation sweep is in progress.

Function
REQ-016 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1.
REQ-017 The word index SHALL be req_addr modulo 2^DEPTH_LOG2 (the low DEPTH_LOG2 bits); upper address bits SHALL be ignored, with no error.
REQ-018 An accepted write SHALL update only the bytes with req_be set, on the accept edge, and SHALL produce no response.
REQ-019 An accepted read SHALL assert rsp_valid on the next edge, with rsp_rdata equal to the word content at the accept edge (1-cycle latency).
REQ-020 A read accepted on the edge after a write to the same index SHALL return the newly written bytes.
REQ-021 While rsp_valid=1 and rsp_ready=0, rsp_rdata SHALL hold stable and req_ready SHALL be 0 for both reads and writes.
REQ-022 rsp_valid SHALL clear on an edge where rsp_ready=1 and no new read is accepted; back-to-back reads SHALL be accepted every cycle while rsp_ready=1.
REQ-023 rsp_rdata SHALL retain its last value while rsp_valid=0.
REQ-024 The FSM SHALL have states INIT and RUN, with req_ready = (state==RUN) && !(rsp_valid && !rsp_ready) and busy = (state==INIT).
REQ-025 INIT SHALL use a DEPTH_LOG2-bit counter to write zero to one index per edge, starting at 0; after the edge that clears index 2^DEPTH_LOG2-1 the FSM SHALL enter RUN; the sweep therefore takes exactly 2^DEPTH_LOG2 edges.
REQ-026 Request inputs SHALL be ignored in INIT.

Reset
REQ-027 rst_n=0 SHALL immediately force state=INIT (RUN when the feature in REQ-029 is excluded), counter=0, rsp_valid=0 and rsp_rdata=0.
REQ-028 Reset asserted mid-sweep or mid-response SHALL abort the operation; the sweep SHALL restart from index 0 after release, and stored contents SHALL not be changed by reset itself.

Configuration
REQ-029 The INIT sweep SHALL be compiled in when macro PARAM_RAM_INIT_CLEAR_EN is defined.
REQ-030 Without PARAM_RAM_INIT_CLEAR_EN, reset SHALL enter RUN directly, busy SHALL be tied 0, req_ready SHALL be 1 on the first edge after release, and contents SHALL be uninitialised until written.

Verification
REQ-031 The bench SHALL cover initialisation: define PARAM_RAM_INIT_CLEAR_EN, reset, then count edges -> busy=1 for exactly 4096 edges; then read address 0xFFFFFFFF -> rsp_rdata=0 from index 4095.
REQ-032 The bench SHALL cover wrap-around: write 14528 to address 0 and 526421 to address 0xA7E5FBDC, then read both -> 14528 and 526421 (index 3036); write 14528 to 0xA7E5FBDC and read it -> 14528.
REQ-033 The bench SHALL cover byte enables: write 0x11223344 with be=1111 then 0xAABBCCDD with be=0101 to address 2001 -> read returns 0x11BB33DD.
REQ-034 The bench SHALL cover backpressure: read address 2001 with rsp_ready=0 for 3 cycles -> rsp_valid=1, rsp_rdata stable, req_ready=0, and the pending write is not applied until rsp_ready=1.
REQ-035 The bench SHALL cover reset mid-sweep: assert rst_n=0 at sweep index 100 -> rsp_valid=0 immediately; after release busy=1 for a full 4096 edges.
REQ-036 The bench SHALL cover read-after-write: write 2 to address 4095 and read it on the next edge -> rsp_valid=1 one edge later with rsp_rdata=2.

Source files
------------

// File: rtl/param_ram.sv
// Single-port word RAM with byte enables, 1-cycle registered read and response backpressure.
// Optional power-on zero sweep is compiled in with `define PARAM_RAM_INIT_CLEAR_EN.
module param_ram #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  busy
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;

    logic                  run;
    logic                  clr_en;
    logic [DEPTH_LOG2-1:0] clr_idx;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  accept;
    logic                  rd_acc;
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [DATA_W-1:0]     wr_data;
    logic [BE_W-1:0]       wr_be;

    assign idx = req_addr[DEPTH_LOG2-1:0];

    if (ADDR_W > DEPTH_LOG2) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = |req_addr[ADDR_W-1:DEPTH_LOG2];
    end

`ifdef PARAM_RAM_INIT_CLEAR_EN
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign run     = (state_q == ST_RUN);
    assign busy    = (state_q == ST_INIT);
    assign clr_en  = (state_q == ST_INIT);
    assign clr_idx = cnt_q;
`else
    assign run     = 1'b1;
    assign busy    = 1'b0;
    assign clr_en  = 1'b0;
    assign clr_idx = '0;
`endif

    // A stalled response blocks writes too, so ordering against the held read is preserved.
    assign req_ready = run && !(rsp_valid_q && !rsp_ready);
    assign accept    = req_valid && req_ready;
    assign rd_acc    = accept && !req_write;

    always_comb begin
        wr_en   = clr_en || (accept && req_write);
        wr_idx  = clr_en ? clr_idx : idx;
        wr_data = clr_en ? '0 : req_wdata;
        wr_be   = clr_en ? '1 : req_be;
    end

    // Storage has no reset: reset never alters contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (wr_be[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        if (rd_acc) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = mem_q[idx];
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_param_ram.sv
// Directed self-checking bench for param_ram; sweep tests run when PARAM_RAM_INIT_CLEAR_EN is defined.
module tb_param_ram;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned DL = 12;

`ifdef PARAM_RAM_INIT_CLEAR_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [3:0]    req_be = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    param_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(DL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_ready(input string what);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: req_ready got 0 after 50 cycles, required 1", what);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_be    = b;
        wait_ready("wr_ready");
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic v);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = a;
        wait_ready("rd_ready");
        @(negedge clk);
        req_valid = 1'b0;
        v = rsp_valid;
        d = rsp_rdata;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
        n_checks++;
        if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h required 0", rsp_rdata); end
        n_checks++;
        if (busy !== INIT_EN) begin n_fail++; $display("FAIL reset_busy: got %b required %b", busy, INIT_EN); end
        n_checks++;
        if (req_ready !== !INIT_EN) begin n_fail++; $display("FAIL reset_req_ready: got %b required %b", req_ready, !INIT_EN); end
    endtask

    task automatic test_init;
        logic [31:0] d;
        logic        v;
        int          n;
        rst_n = 1'b1;
`ifdef PARAM_RAM_INIT_CLEAR_EN
        n = 0;
        while (busy && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (n !== 4096) begin n_fail++; $display("FAIL init_sweep_len: got %0d edges required 4096", n); end
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL init_ready_after: got %b required 1", req_ready); end
        @(negedge clk);
        rd(32'hFFFF_FFFF, d, v);
        n_checks++;
        if (v !== 1'b1) begin n_fail++; $display("FAIL init_rd_valid: got %b required 1", v); end
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL init_rd_4095: got %h required 0", d); end
`else
        @(posedge clk);
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL noinit_ready: got %b required 1", req_ready); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL noinit_busy: got %b required 0", busy); end
        @(negedge clk);
`endif
    endtask

    task automatic test_wrap;
        logic [31:0] d;
        logic        v;
        wr(32'h0000_0000, 32'd14528, 4'hF);
        wr(32'hA7E5_FBDC, 32'd526421, 4'hF);
        rd(32'h0000_0000, d, v);
        n_checks++;
        if (v !== 1'b1 || d !== 32'd14528) begin n_fail++; $display("FAIL wrap_rd0: got v=%b %0d required v=1 14528", v, d); end
        rd(32'hA7E5_FBDC, d, v);
        n_checks++;
        if (v !== 1'b1 || d !== 32'd526421) begin n_fail++; $display("FAIL wrap_rd3036: got v=%b %0d required v=1 526421", v, d); end
        wr(32'hA7E5_FBDC, 32'd14528, 4'hF);
        rd(32'hA7E5_FBDC, d, v);
        n_checks++;
        if (d !== 32'd14528) begin n_fail++; $display("FAIL wrap_rewrite: got %0d required 14528", d); end
        rd(32'h0000_0BDC, d, v);
        n_checks++;
        if (d !== 32'd14528) begin n_fail++; $display("FAIL wrap_alias: got %0d required 14528", d); end
    endtask

    task automatic test_byte_en;
        logic [31:0] d;
        logic        v;
        wr(32'd2001, 32'h1122_3344, 4'b1111);
        wr(32'd2001, 32'hAABB_CCDD, 4'b0101);
        rd(32'd2001, d, v);
        n_checks++;
        if (d !== 32'h11BB_33DD) begin n_fail++; $display("FAIL byte_en: got %h required 11bb33dd", d); end
    endtask

    task automatic test_backpressure;
        logic [31:0] d;
        logic        v;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'd2001;
        wait_ready("bp_rd_ready");
        @(negedge clk);
        req_write = 1'b1;
        req_wdata = 32'hDEAD_BEEF;
        req_be    = 4'hF;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b required 1", i, rsp_valid); end
            n_checks++;
            if (rsp_rdata !== 32'h11BB_33DD) begin n_fail++; $display("FAIL bp_rdata[%0d]: got %h required 11bb33dd", i, rsp_rdata); end
            n_checks++;
            if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b required 0", i, req_ready); end
            if (i < 3) @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b required 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_cleared: got %b required 0", rsp_valid); end
        n_checks++;
        if (rsp_rdata !== 32'h11BB_33DD) begin n_fail++; $display("FAIL bp_retain: got %h required 11bb33dd", rsp_rdata); end
        rd(32'd2001, d, v);
        n_checks++;
        if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bp_write_applied: got %h required deadbeef", d); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] addrs [4];
        logic [31:0] exps  [4];
        addrs = '{32'd2001, 32'h0, 32'h1000_07D1, 32'h0000_0BDC};
        exps  = '{32'hDEAD_BEEF, 32'd14528, 32'hDEAD_BEEF, 32'd14528};
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_addr = addrs[i];
            #1;
            n_checks++;
            if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b required 1", i, req_ready); end
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== exps[i]) begin
                n_fail++;
                $display("FAIL b2b_rd[%0d]: got v=%b %h required v=1 %h", i, rsp_valid, rsp_rdata, exps[i]);
            end
        end
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b required 0", rsp_valid); end
    endtask

    task automatic test_read_after_write;
        logic [31:0] d;
        logic        v;
        wr(32'd4095, 32'd2, 4'hF);
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL raw_write_no_rsp: got %b required 0", rsp_valid); end
        rd(32'd4095, d, v);
        n_checks++;
        if (v !== 1'b1 || d !== 32'd2) begin n_fail++; $display("FAIL raw_rd: got v=%b %0d required v=1 2", v, d); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        logic        v;
        int          n;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'd4095;
        wait_ready("mid_rd_ready");
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd2) begin
            n_fail++;
            $display("FAIL mid_pending: got v=%b %0d required v=1 2", rsp_valid, rsp_rdata);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rsp_abort: got %b required 0", rsp_valid); end
        n_checks++;
        if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL mid_rdata_clr: got %h required 0", rsp_rdata); end
        @(negedge clk);
        rsp_ready = 1'b1;
        rst_n     = 1'b1;
`ifdef PARAM_RAM_INIT_CLEAR_EN
        // Request held through the sweep must be ignored.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'd5;
        req_wdata = 32'h5A5A_5A5A;
        req_be    = 4'hF;
        repeat (100) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (busy !== 1'b1 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_idx100: got busy=%b ready=%b required busy=1 ready=0", busy, req_ready);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_abort: got v=%b busy=%b required v=0 busy=1", rsp_valid, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (busy && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (n !== 4096) begin n_fail++; $display("FAIL sweep_restart_len: got %0d edges required 4096", n); end
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'b0;
        rd(32'd5, d, v);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL sweep_ignored_wr: got %h required 0", d); end
        rd(32'd4095, d, v);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL sweep_cleared: got %h required 0", d); end
`else
        rd(32'd4095, d, v);
        n_checks++;
        if (v !== 1'b1 || d !== 32'd2) begin n_fail++; $display("FAIL keep_4095: got v=%b %0d required v=1 2", v, d); end
        rd(32'd2001, d, v);
        n_checks++;
        if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL keep_2001: got %h required deadbeef", d); end
`endif
    endtask

    initial begin
        test_reset();
        test_init();
        test_wrap();
        test_byte_en();
        test_backpressure();
        test_back_to_back();
        test_read_after_write();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
